rotate_stream_8: RTL

- Sequential front end for the 8-bit multifunction barrel shifter.
- Accepts rotate commands (data, amount, direction) over a valid/ready handshake and buffers them in a small FIFO.
- Drives each command through one instance of the existing combinational barrel_shifter_8 and holds the result in a registered, back-pressurable output stage.
- Lets switch/UART/CPU sources issue rotate jobs without meeting combinational timing into downstream logic.

---
 rtl/rotate_stream_pkg.sv | 25 ++
 rtl/barrel_shifter_8.sv | 38 +++
 rtl/rot_cmd_fifo.sv | 68 ++++++
 rtl/rotate_stream_8.sv | 128 ++++++++++++
 4 files changed

// File: rtl/rotate_stream_pkg.sv
// -----------------------------------------------------------------------------
// rotate_stream_pkg
// Shared definitions for the rotate_stream_8 front end: the width of one
// queued rotate command, the bit offsets of its fields inside the FIFO word,
// and a packed struct that builds that word from the input ports.
// Ports: none (package).
// -----------------------------------------------------------------------------
package rotate_stream_pkg;

    // One command is {lr, amt[2:0], data[7:0]} = 1 + 3 + 8 bits
    localparam int CMD_W    = 12;
    localparam int LR_BIT   = 11;
    localparam int AMT_MSB  = 10;
    localparam int AMT_LSB  = 8;
    localparam int DATA_MSB = 7;

    // Field order matches the offsets above so the struct can be stored
    // directly as a CMD_W-bit FIFO word
    typedef struct packed {
        logic       lr;
        logic [2:0] amt;
        logic [7:0] data;
    } rotCmd_t;

endpackage

// File: rtl/barrel_shifter_8.sv
// -----------------------------------------------------------------------------
// barrel_shifter_8
// Combinational 8-bit rotator, built as three mux stages (rotate by 1, 2, 4)
// selected by the bits of amt.
// Ports:
//   num  in  8  operand
//   amt  in  3  rotate amount 0-7
//   LR   in  1  1 = rotate left, 0 = rotate right
//   out  out 8  rotated operand
// -----------------------------------------------------------------------------
module barrel_shifter_8 (
    input  logic [7:0] num,
    input  logic [2:0] amt,
    input  logic       LR,
    output logic [7:0] out
);

    logic [7:0] w_stage1;
    logic [7:0] w_stage2;

    // Each stage rotates by a power of two when its amt bit is set; a left
    // rotate moves bit i to i+k, a right rotate moves bit i+k down to i
    always_comb begin
        w_stage1 = num;
        if (amt[0]) begin
            w_stage1 = LR ? {num[6:0], num[7]} : {num[0], num[7:1]};
        end
        w_stage2 = w_stage1;
        if (amt[1]) begin
            w_stage2 = LR ? {w_stage1[5:0], w_stage1[7:6]} : {w_stage1[1:0], w_stage1[7:2]};
        end
        out = w_stage2;
        if (amt[2]) begin
            out = {w_stage2[3:0], w_stage2[7:4]};
        end
    end

endmodule

// File: rtl/rot_cmd_fifo.sv
// -----------------------------------------------------------------------------
// rot_cmd_fifo
// Synchronous command FIFO, CMD_W bits x FIFO_DEPTH entries. Full and empty
// are told apart by the occupancy counter, so the pointers simply wrap.
// The caller is responsible for only pushing when not full and only popping
// when not empty.
// Ports:
//   clk          in   clock
//   reset        in   synchronous active-high reset
//   i_push       in   write i_pushData at the write pointer
//   i_pushData   in   CMD_W command word
//   i_pop        in   retire the head entry
//   o_headData   out  combinational read of the head entry
//   o_count      out  occupancy 0..FIFO_DEPTH
// -----------------------------------------------------------------------------
module rot_cmd_fifo
    import rotate_stream_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int PTR_W      = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [CMD_W-1:0] i_pushData,
    input  logic             i_pop,
    output logic [CMD_W-1:0] o_headData,
    output logic [PTR_W:0]   o_count
);

    logic [CMD_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [PTR_W:0]   r_count;

    // Storage has no reset: an entry is only ever read after it was written
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wrPtr] <= i_pushData;
        end
    end

    // Pointers wrap naturally because the depth is a power of two; the count
    // only moves when exactly one of push/pop happens
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (i_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_headData = r_mem[r_rdPtr];
    assign o_count    = r_count;

endmodule

// File: rtl/rotate_stream_8.sv
// -----------------------------------------------------------------------------
// rotate_stream_8
// Sequential front end for barrel_shifter_8. Rotate commands arrive over a
// valid/ready handshake, wait in a small FIFO, pass through the rotator and
// land in a registered, back-pressurable output stage.
// Optional build macro: ROT_STREAM_STATS_EN adds saturating transfer/stall
// counters on stat_done and stat_stall.
// Ports:
//   clk         in   clock
//   reset       in   synchronous active-high reset
//   in_valid    in   command present on in_data/in_amt/in_lr
//   in_ready    out  a command can be accepted this cycle
//   in_data     in   8-bit operand
//   in_amt      in   rotate amount 0-7
//   in_lr       in   1 = left, 0 = right
//   out_valid   out  out_data holds an unconsumed result
//   out_ready   in   consumer takes the result this cycle
//   out_data    out  rotated result
//   fifo_count  out  FIFO occupancy (output register not included)
//   stat_done   out  completed output transfers (ROT_STREAM_STATS_EN only)
//   stat_stall  out  cycles with a refused input (ROT_STREAM_STATS_EN only)
// -----------------------------------------------------------------------------
module rotate_stream_8
    import rotate_stream_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int PTR_W      = 2
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [7:0]     in_data,
    input  logic [2:0]     in_amt,
    input  logic           in_lr,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [7:0]     out_data,
`ifdef ROT_STREAM_STATS_EN
    output logic [15:0]    stat_done,
    output logic [15:0]    stat_stall,
`endif
    output logic [PTR_W:0] fifo_count
);

    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(FIFO_DEPTH);

    rotCmd_t          w_pushCmd;
    logic [CMD_W-1:0] w_headBits;
    logic [PTR_W:0]   w_count;
    logic             w_push;
    logic             w_advance;
    logic [7:0]       w_rotated;
    logic             r_outValid;
    logic [7:0]       r_outData;

    assign w_pushCmd = '{lr: in_lr, amt: in_amt, data: in_data};

    // in_ready looks only at registered occupancy, so it never depends on
    // in_valid or out_ready; a full FIFO refuses input even if a pop happens
    // in the same cycle
    assign in_ready  = (w_count != FULL_COUNT);
    assign w_push    = in_valid && in_ready;
    assign w_advance = (w_count != '0) && (!r_outValid || out_ready);

    rot_cmd_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .PTR_W      (PTR_W)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .i_push     (w_push),
        .i_pushData (w_pushCmd),
        .i_pop      (w_advance),
        .o_headData (w_headBits),
        .o_count    (w_count)
    );

    barrel_shifter_8 u_shifter (
        .num (w_headBits[DATA_MSB:0]),
        .amt (w_headBits[AMT_MSB:AMT_LSB]),
        .LR  (w_headBits[LR_BIT]),
        .out (w_rotated)
    );

    // Output register: load a new result whenever the head can move forward,
    // otherwise let a consumed result go empty. When stalled nothing changes,
    // and out_data keeps its last value after a drain
    always_ff @(posedge clk) begin
        if (reset) begin
            r_outValid <= 1'b0;
            r_outData  <= 8'h00;
        end else if (w_advance) begin
            r_outValid <= 1'b1;
            r_outData  <= w_rotated;
        end else if (out_ready) begin
            r_outValid <= 1'b0;
        end
    end

    assign out_valid  = r_outValid;
    assign out_data   = r_outData;
    assign fifo_count = w_count;

`ifdef ROT_STREAM_STATS_EN
    logic [15:0] r_statDone;
    logic [15:0] r_statStall;

    // Saturating event counters; they stop at all-ones rather than wrapping
    always_ff @(posedge clk) begin
        if (reset) begin
            r_statDone  <= '0;
            r_statStall <= '0;
        end else begin
            if (r_outValid && out_ready && (r_statDone != 16'hFFFF)) begin
                r_statDone <= r_statDone + 1'b1;
            end
            if (in_valid && !in_ready && (r_statStall != 16'hFFFF)) begin
                r_statStall <= r_statStall + 1'b1;
            end
        end
    end

    assign stat_done  = r_statDone;
    assign stat_stall = r_statStall;
`endif

endmodule
